// File: rtl/icache_line_fill_ctrl.sv
// Hit/miss classifier and 16-byte line-fill controller for the 32-line instruction cache.
// Define ICACHE_CRITICAL_FIRST_EN to start each fill at the requested byte and wrap.
module icache_line_fill_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [11:0] diff,
  input  logic [11:0] pc_hi,
  input  logic        flush,
  output logic        ready,
  output logic        bypass,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        cram_we,
  output logic [8:0]  cram_addr,
  output logic [7:0]  cram_wdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] valid_q, valid_d;
  logic [4:0]  line_q, line_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  bytes_q, bytes_d;
  logic        ready_q, ready_d;
  logic        bypass_q, bypass_d;

  logic        in_range;
  logic        in_fill;
  logic        fill_ack;
  logic [3:0]  start_off;

  assign in_range = (diff[11:9] == 3'b000);
  assign in_fill  = (state_q == StFill);
  assign fill_ack = in_fill & mem_ack;

`ifdef ICACHE_CRITICAL_FIRST_EN
  assign start_off = diff[3:0];
`else
  logic unused_diff_lo;
  assign unused_diff_lo = ^diff[3:0];
  assign start_off      = 4'd0;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    line_d   = line_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    bytes_d  = bytes_q;
    ready_d  = 1'b0;
    bypass_d = 1'b0;

    case (state_q)
      StIdle: begin
        // The cycle carrying a ready/bypass pulse belongs to the finished request.
        if (req && !ready_q && !bypass_q) begin
          if (!in_range) begin
            bypass_d = 1'b1;
          end else if (valid_q[diff[8:4]] && !flush) begin
            ready_d = 1'b1;
          end else begin
            line_d  = diff[8:4];
            base_d  = pc_hi;
            cnt_d   = start_off;
            bytes_d = 4'd0;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (mem_ack) begin
          cnt_d   = cnt_q + 4'd1;
          bytes_d = bytes_q + 4'd1;
          if (bytes_q == 4'd15) begin
            valid_d[line_q] = 1'b1;
            state_d         = StDone;
          end
        end
        if (flush) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush beats a coinciding final ack, so the line never becomes valid.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      valid_q  <= '0;
      line_q   <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      bytes_q  <= '0;
      ready_q  <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      line_q   <= line_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      bytes_q  <= bytes_d;
      ready_q  <= ready_d;
      bypass_q <= bypass_d;
    end
  end

  assign ready      = ready_q;
  assign bypass     = bypass_q;
  assign mem_req    = in_fill;
  assign mem_addr   = in_fill ? {base_q, cnt_q} : 16'h0000;
  assign cram_we    = fill_ack;
  assign cram_addr  = fill_ack ? {line_q, cnt_q} : 9'h000;
  assign cram_wdata = fill_ack ? mem_data : 8'h00;

endmodule

// File: tb/tb_icache_line_fill_ctrl.sv
// Scoreboard bench for icache_line_fill_ctrl: expected events are queued at issue time from a
// line-validity model; a negedge monitor pops and compares every ready, bypass and cache write.
module tb_icache_line_fill_ctrl;

  localparam int KWrite  = 0;
  localparam int KReady  = 1;
  localparam int KBypass = 2;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        req     = 1'b0;
  logic [11:0] diff    = '0;
  logic [11:0] pc_hi   = '0;
  logic        flush   = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        ready, bypass, mem_req, cram_we;
  logic [15:0] mem_addr;
  logic [8:0]  cram_addr;
  logic [7:0]  cram_wdata;

  icache_line_fill_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .diff       (diff),
    .pc_hi      (pc_hi),
    .flush      (flush),
    .ready      (ready),
    .bypass     (bypass),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .cram_we    (cram_we),
    .cram_addr  (cram_addr),
    .cram_wdata (cram_wdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [8:0]  caddr;
    logic [7:0]  cdata;
    logic [15:0] maddr;
    bit          after_fill;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  bit [31:0]   model_valid = '0;
  bit          abort_run = 1'b0;

  function automatic logic [7:0] memfn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_ev(input int kind, input logic [8:0] ca, input logic [7:0] cd,
                                  input logic [15:0] ma, input bit af);
    exp_t e;
    e.kind = kind; e.caddr = ca; e.cdata = cd; e.maddr = ma; e.after_fill = af;
    sb.push_back(e);
  endfunction

  function automatic void push_fill(input logic [4:0] line, input logic [11:0] base,
                                    input logic [3:0] start, input int n);
    logic [3:0] off;
    for (int i = 0; i < n; i++) begin
      off = start + 4'(i);
      push_ev(KWrite, {line, off}, memfn({base, off}), {base, off}, 1'b0);
    end
  endfunction

  function automatic void mon_check(input int k);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fails++;
      $display("FAIL unexpected_event: got kind %0d cram_addr=%h, expected no event", k, cram_addr);
      return;
    end
    e = sb.pop_front();
    if (k == KWrite) begin
      if (e.kind != KWrite || cram_addr !== e.caddr || cram_wdata !== e.cdata ||
          mem_addr !== e.maddr) begin
        n_fails++;
        $display("FAIL write_event: got kind=%0d cram_addr=%h data=%h mem_addr=%h, expected kind=%0d cram_addr=%h data=%h mem_addr=%h",
                 k, cram_addr, cram_wdata, mem_addr, e.kind, e.caddr, e.cdata, e.maddr);
      end
      last_we_cyc = cyc;
    end else if (e.kind != k) begin
      n_fails++;
      $display("FAIL event_kind: got kind %0d, expected kind %0d", k, e.kind);
    end else if (k == KReady && e.after_fill) begin
      chk("ready_after_last_ack", 32'(cyc - last_we_cyc), 32'd2);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    if (cram_we) mon_check(KWrite);
    if (ready)   mon_check(KReady);
    if (bypass)  mon_check(KBypass);
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ready"},      32'(ready),      32'd0);
    chk({tag, "_bypass"},     32'(bypass),     32'd0);
    chk({tag, "_mem_req"},    32'(mem_req),    32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_cram_we"},    32'(cram_we),    32'd0);
    chk({tag, "_cram_addr"},  32'(cram_addr),  32'd0);
    chk({tag, "_cram_wdata"}, 32'(cram_wdata), 32'd0);
  endtask

  task automatic do_txn(input logic [11:0] d, input logic [11:0] ph, input int abort_k,
                        input bit coinc, input int ack_pct);
    logic [4:0] line;
    logic [3:0] start;
    bit miss, flushed, flush_prev, saw_mreq;
    int cycles, acks;
    @(posedge clk); #1;
    line = d[8:4];
`ifdef ICACHE_CRITICAL_FIRST_EN
    start = d[3:0];
`else
    start = 4'd0;
`endif
    miss = 1'b0;
    if (d[11:9] != 3'b000) begin
      push_ev(KBypass, '0, '0, '0, 1'b0);
    end else if (model_valid[line]) begin
      push_ev(KReady, '0, '0, '0, 1'b0);
    end else begin
      miss = 1'b1;
      if (abort_k >= 0) begin
        push_fill(line, ph, start, abort_k + int'(coinc));
        model_valid = '0;
      end
      push_fill(line, ph, start, 16);
      push_ev(KReady, '0, '0, '0, 1'b1);
      model_valid[line] = 1'b1;
    end
    req = 1'b1; diff = d; pc_hi = ph;
    cycles = 0; acks = 0; flushed = 1'b0; flush_prev = 1'b0; saw_mreq = 1'b0;
    forever begin
      @(posedge clk); #1;
      cycles++;
      mem_ack = 1'b0; flush = 1'b0; mem_data = 8'($urandom);
      if (flush_prev) begin
        chk("mem_req_after_flush", 32'(mem_req), 32'd0);
        flush_prev = 1'b0;
      end
      if (mem_req) saw_mreq = 1'b1;
      if (ready || bypass) begin
        req = 1'b0;
        break;
      end
      if (cycles > 400) begin
        n_checks++; n_fails++;
        $display("FAIL txn_timeout: got no ready/bypass after %0d cycles, expected one", cycles);
        abort_run = 1'b1; req = 1'b0;
        break;
      end
      if (mem_req) begin
        if (miss && abort_k >= 0 && !flushed && acks == abort_k) begin
          flush = 1'b1; flushed = 1'b1; flush_prev = 1'b1;
          mem_ack = coinc;
        end else begin
          mem_ack = ($urandom_range(99) < 32'(ack_pct));
        end
        if (mem_ack) begin
          mem_data = memfn(mem_addr);
          if (!flushed) acks++;
        end
      end else if ($urandom_range(7) == 0) begin
        mem_ack = 1'b1;  // stray ack with no fill in progress
      end
    end
    mem_ack = 1'b0;
    flush = 1'b0;
    if (!abort_run) begin
      if (!miss) begin
        chk("hit_bypass_latency", 32'(cycles), 32'd1);
        chk("hit_bypass_no_mem_req", 32'(saw_mreq), 32'd0);
      end else if (ack_pct == 100 && abort_k < 0) begin
        chk("miss_latency_zero_wait", 32'(cycles), 32'd18);
      end
    end
  endtask

  task automatic do_reset_fill(input logic [11:0] d, input logic [11:0] ph, input int k);
    logic [4:0] line;
    logic [3:0] start;
    int acks, cycles;
    @(posedge clk); #1;
    line = d[8:4];
`ifdef ICACHE_CRITICAL_FIRST_EN
    start = d[3:0];
`else
    start = 4'd0;
`endif
    if (d[11:9] != 3'b000 || model_valid[line]) return;
    push_fill(line, ph, start, k);
    req = 1'b1; diff = d; pc_hi = ph;
    acks = 0; cycles = 0;
    forever begin
      @(posedge clk); #1;
      cycles++;
      mem_ack = 1'b0;
      if (cycles > 100) begin
        n_checks++; n_fails++;
        $display("FAIL reset_fill_timeout: got %0d acks, expected %0d", acks, k);
        abort_run = 1'b1;
        break;
      end
      if (mem_req && acks == k) break;
      if (mem_req) begin
        mem_ack = 1'b1; mem_data = memfn(mem_addr); acks++;
      end
    end
    #1 reset_n = 1'b0;
    req = 1'b0;
    model_valid = '0;
    #1 check_zero("reset_mid_fill");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
    $fatal(1);
  end

  initial begin
    logic [11:0] d, ph;
    int ak, r;
    #3 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    do_txn(12'h025, 12'h802, -1, 1'b0, 100);
    do_txn(12'h02A, 12'h802, -1, 1'b0, 100);
    do_txn(12'h200, 12'h123, -1, 1'b0, 100);
    do_txn(12'hFFF, 12'h456, -1, 1'b0, 100);
    do_txn(12'h035, 12'h803, 5, 1'b0, 100);
    do_txn(12'h025, 12'h802, -1, 1'b0, 100);
    do_txn(12'h045, 12'h804, 15, 1'b1, 100);
    do_reset_fill(12'h065, 12'h806, 4);
    do_txn(12'h045, 12'h804, -1, 1'b0, 100);

    for (int t = 0; t < 150 && !abort_run; t++) begin
      r = int'($urandom_range(11));
      if (r == 0) begin
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model_valid = '0;
      end
      if (r == 1 || r == 2) d = {3'($urandom_range(7, 1)), 9'($urandom)};
      else d = {5'b00000, 3'($urandom_range(7)), 4'($urandom)};
      ph = 12'($urandom);
      ak = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : -1;
      do_txn(d, ph, ak, 1'($urandom), ($urandom_range(1) == 1) ? 100 : 60);
    end

    repeat (5) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
